// File: rtl/stage_id_pkg.sv
// stage_id_pkg
//   Shared definitions for the ID stage: the MIPS opcode and function-field
//   encodings it decodes, and the operand-forwarding select used to pick
//   where each source operand comes from.
package stage_id_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  // Where a source operand is taken from
  typedef enum logic [1:0] {
    REG     = 2'd0,
    EX      = 2'd1,
    MEM_ALU = 2'd2,
    MEM_MO  = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/stage_id_pipe_if.sv
// stage_id_pipe_if
//   The ID/EX boundary bundle: the registered decoded instruction handed to
//   stage_ex, plus the ex_ready back-pressure returned by EX.
//   master : ID stage (drives idex_*, receives ex_ready)
//   slave  : EX stage (receives idex_*, drives ex_ready)
interface stage_id_pipe_if #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
);
  logic             idex_valid;
  logic [5:0]       idex_op;
  logic [5:0]       idex_func;
  logic [XLEN-1:0]  idex_a;
  logic [XLEN-1:0]  idex_b;
  logic [XLEN-1:0]  idex_imm;
  logic [RADDR-1:0] idex_rn;
  logic             idex_we;
  logic             ex_ready;

  modport master (
    output idex_valid, idex_op, idex_func, idex_a, idex_b, idex_imm,
           idex_rn, idex_we,
    input  ex_ready
  );

  modport slave (
    input  idex_valid, idex_op, idex_func, idex_a, idex_b, idex_imm,
           idex_rn, idex_we,
    output ex_ready
  );
endinterface

// File: rtl/id_regfile.sv
// id_regfile
//   NREG x XLEN architectural register file, two read ports and one write
//   port. r0 is hard-wired to zero. A read of the register being written in
//   the same cycle returns the incoming write data, so WB never needs a
//   separate forwarding path into ID.
//   Ports: clock, reset_0 (async active-low), ra_rs/ra_rt -> rd_rs/rd_rt
//          read ports, we/wn/wd write port.
module id_regfile
  import stage_id_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clock,
  input  logic             reset_0,
  input  logic [RADDR-1:0] ra_rs,
  input  logic [RADDR-1:0] ra_rt,
  output logic [XLEN-1:0]  rd_rs,
  output logic [XLEN-1:0]  rd_rt,
  input  logic             we,
  input  logic [RADDR-1:0] wn,
  input  logic [XLEN-1:0]  wd
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            wr_en;

  // r0 is never written, so it stays at its reset value of zero
  assign wr_en = we && (wn != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wn] = wd;
    end
  end

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Write-through reads: same-cycle write to the addressed register wins
  always_comb begin
    rd_rs = '0;
    rd_rt = '0;
    if (ra_rs != '0) begin
      rd_rs = (wr_en && (wn == ra_rs)) ? wd : regs_q[ra_rs];
    end
    if (ra_rt != '0) begin
      rd_rt = (wr_en && (wn == ra_rt)) ? wd : regs_q[ra_rt];
    end
  end

endmodule

// File: rtl/stage_id_pipe.sv
// stage_id_pipe
//   Decode stage of the 5-stage MIPS pipeline. Decodes the IF/ID instruction,
//   reads the register file, forwards operands from EX and MEM, resolves
//   branches and jumps in ID, interlocks on load-use, and registers the result
//   into the ID/EX boundary with back-pressure from EX.
//   Ports:
//     clock, reset_0           clock, async active-low reset
//     in_valid/pc_add4/instr   IF/ID contents
//     wb_*                     writeback port into the register file
//     ex_*, mem_*              in-flight destinations/results for forwarding
//     stall_if, flush_if       hold / squash the IF side
//     redirect, redirect_pc    taken branch or jump and its target
//     idex (master)            registered ID/EX fields and ex_ready
module stage_id_pipe
  import stage_id_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int RADDR      = 5,
  parameter int DELAY_SLOT = 1
) (
  input  logic             clock,
  input  logic             reset_0,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  pc_add4,
  input  logic [31:0]      instr,
  input  logic             wb_we,
  input  logic [RADDR-1:0] wb_rn,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             ex_we,
  input  logic [RADDR-1:0] ex_rn,
  input  logic             ex_is_load,
  input  logic [XLEN-1:0]  ex_alu,
  input  logic             mem_we,
  input  logic [RADDR-1:0] mem_rn,
  input  logic             mem_is_load,
  input  logic [XLEN-1:0]  mem_alu,
  input  logic [XLEN-1:0]  mem_mo,
  output logic             stall_if,
  output logic             flush_if,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  stage_id_pipe_if.master  idex
);

  // Instruction fields
  logic [5:0]       op;
  logic [5:0]       func;
  logic [RADDR-1:0] rs;
  logic [RADDR-1:0] rt;
  logic [RADDR-1:0] rd;
  logic [15:0]      imm16;

  assign op    = instr[31:26];
  assign func  = instr[5:0];
  assign rs    = RADDR'(instr[25:21]);
  assign rt    = RADDR'(instr[20:16]);
  assign rd    = RADDR'(instr[15:11]);
  assign imm16 = instr[15:0];

  // Decoded control
  logic             is_r, is_j, is_jal, is_beq, is_bne, is_sw, is_lui, is_logic;
  logic             uses_rs, uses_rt, dec_we;
  logic [RADDR-1:0] dec_rn;
  logic [XLEN-1:0]  imm_ext;

  always_comb begin
    is_r     = (op == OP_RTYPE);
    is_j     = (op == OP_J);
    is_jal   = (op == OP_JAL);
    is_beq   = (op == OP_BEQ);
    is_bne   = (op == OP_BNE);
    is_sw    = (op == OP_SW);
    is_lui   = (op == OP_LUI);
    is_logic = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);

    uses_rs  = !(is_j || is_jal || is_lui);
    uses_rt  = is_r || is_beq || is_bne || is_sw;
    dec_we   = !(is_sw || is_beq || is_bne || is_j);

    if (is_jal) begin
      dec_rn = RADDR'(31);
    end else if (is_r) begin
      dec_rn = rd;
    end else begin
      dec_rn = rt;
    end

    // Logical immediates and lui are zero-extended; everything else is
    // sign-extended (for R-type the low half-word is simply carried along)
    if (is_logic || is_lui) begin
      imm_ext = {{(XLEN-16){1'b0}}, imm16};
    end else begin
      imm_ext = {{(XLEN-16){imm16[15]}}, imm16};
    end
  end

  // Register file
  logic [XLEN-1:0] rf_a, rf_b;

  id_regfile #(
    .NREG  (NREG),
    .XLEN  (XLEN),
    .RADDR (RADDR)
  ) u_regfile (
    .clock   (clock),
    .reset_0 (reset_0),
    .ra_rs   (rs),
    .ra_rt   (rt),
    .rd_rs   (rf_a),
    .rd_rt   (rf_b),
    .we      (wb_we),
    .wn      (wb_rn),
    .wd      (wb_data)
  );

  // A load in EX has no data yet, so it is never a forwarding source; that
  // case is covered by the load-use interlock instead.
  function automatic fwd_sel_e fwd_pick(
    input logic [RADDR-1:0] src,
    input logic             e_we,
    input logic [RADDR-1:0] e_rn,
    input logic             e_ld,
    input logic             m_we,
    input logic [RADDR-1:0] m_rn,
    input logic             m_ld
  );
    if (e_we && (e_rn == src) && !e_ld) begin
      return EX;
    end else if (m_we && (m_rn == src)) begin
      return m_ld ? MEM_MO : MEM_ALU;
    end
    return REG;
  endfunction

  fwd_sel_e        sel_a, sel_b;
  logic [XLEN-1:0] op_a, op_b;

  always_comb begin
    sel_a = fwd_pick(rs, ex_we, ex_rn, ex_is_load, mem_we, mem_rn, mem_is_load);
    sel_b = fwd_pick(rt, ex_we, ex_rn, ex_is_load, mem_we, mem_rn, mem_is_load);

    case (sel_a)
      EX:      op_a = ex_alu;
      MEM_ALU: op_a = mem_alu;
      MEM_MO:  op_a = mem_mo;
      default: op_a = rf_a;
    endcase
    case (sel_b)
      EX:      op_b = ex_alu;
      MEM_ALU: op_b = mem_alu;
      MEM_MO:  op_b = mem_mo;
      default: op_b = rf_b;
    endcase

    // r0 must read zero even if some in-flight instruction targets it
    if (rs == '0) begin
      op_a = '0;
    end
    if (rt == '0) begin
      op_b = '0;
    end
  end

  // Hazard, branch resolution and IF control
  logic            load_use, bp_hold, br_taken;
  logic [XLEN-1:0] br_target, j_target;

  always_comb begin
    load_use = in_valid && ex_we && ex_is_load && (ex_rn != '0) &&
               ((uses_rs && (ex_rn == rs)) || (uses_rt && (ex_rn == rt)));
    bp_hold  = idex.idex_valid && !idex.ex_ready;
    stall_if = load_use || bp_hold;

    br_taken  = (is_beq && (op_a == op_b)) || (is_bne && (op_a != op_b));
    br_target = pc_add4 + (imm_ext << 2);
    j_target  = {pc_add4[XLEN-1:28], instr[25:0], 2'b00};

    // A stalled instruction will be seen again, so it may not redirect yet
    redirect    = in_valid && !stall_if && (br_taken || is_j || is_jal);
    redirect_pc = (is_j || is_jal) ? j_target : br_target;
    flush_if    = redirect && (DELAY_SLOT == 0);
  end

  // ID/EX register
  logic             idex_valid_q, idex_valid_d;
  logic [5:0]       idex_op_q, idex_op_d;
  logic [5:0]       idex_func_q, idex_func_d;
  logic [XLEN-1:0]  idex_a_q, idex_a_d;
  logic [XLEN-1:0]  idex_b_q, idex_b_d;
  logic [XLEN-1:0]  idex_imm_q, idex_imm_d;
  logic [RADDR-1:0] idex_rn_q, idex_rn_d;
  logic             idex_we_q, idex_we_d;

  // Back-pressure holds everything (even over a hazard); otherwise a hazard
  // or an empty IF/ID inserts a bubble, leaving the data fields untouched.
  always_comb begin
    idex_valid_d = idex_valid_q;
    idex_op_d    = idex_op_q;
    idex_func_d  = idex_func_q;
    idex_a_d     = idex_a_q;
    idex_b_d     = idex_b_q;
    idex_imm_d   = idex_imm_q;
    idex_rn_d    = idex_rn_q;
    idex_we_d    = idex_we_q;

    if (bp_hold) begin
      idex_valid_d = idex_valid_q;
    end else if (load_use || !in_valid) begin
      idex_valid_d = 1'b0;
      idex_we_d    = 1'b0;
    end else begin
      idex_valid_d = 1'b1;
      idex_op_d    = op;
      idex_func_d  = func;
      idex_a_d     = is_jal ? pc_add4 : op_a;
      idex_b_d     = is_jal ? '0 : op_b;
      idex_imm_d   = imm_ext;
      idex_rn_d    = dec_rn;
      idex_we_d    = dec_we;
    end
  end

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      idex_valid_q <= 1'b0;
      idex_op_q    <= '0;
      idex_func_q  <= '0;
      idex_a_q     <= '0;
      idex_b_q     <= '0;
      idex_imm_q   <= '0;
      idex_rn_q    <= '0;
      idex_we_q    <= 1'b0;
    end else begin
      idex_valid_q <= idex_valid_d;
      idex_op_q    <= idex_op_d;
      idex_func_q  <= idex_func_d;
      idex_a_q     <= idex_a_d;
      idex_b_q     <= idex_b_d;
      idex_imm_q   <= idex_imm_d;
      idex_rn_q    <= idex_rn_d;
      idex_we_q    <= idex_we_d;
    end
  end

  assign idex.idex_valid = idex_valid_q;
  assign idex.idex_op    = idex_op_q;
  assign idex.idex_func  = idex_func_q;
  assign idex.idex_a     = idex_a_q;
  assign idex.idex_b     = idex_b_q;
  assign idex.idex_imm   = idex_imm_q;
  assign idex.idex_rn    = idex_rn_q;
  assign idex.idex_we    = idex_we_q;

endmodule

// File: tb/tb_stage_id_pipe.sv
// tb_stage_id_pipe
//   Directed bench for stage_id_pipe. Two instances share every input: one
//   with a delay slot and one that squashes IF on redirect. Each instruction
//   that should reach ID/EX has its expected fields queued when it is driven;
//   a monitor pops and compares whenever the delay-slot instance hands a valid
//   ID/EX entry to EX. Combinational outputs are compared inline.
module tb_stage_id_pipe;
  import stage_id_pkg::*;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rn;
    logic        we;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic        clock = 1'b0;
  logic        reset_0;
  logic        in_valid;
  logic [31:0] pc_add4, instr;
  logic        wb_we, ex_we, ex_is_load, mem_we, mem_is_load, ex_ready;
  logic [4:0]  wb_rn, ex_rn, mem_rn;
  logic [31:0] wb_data, ex_alu, mem_alu, mem_mo;
  logic        stall_if, flush_if, redirect;
  logic [31:0] redirect_pc;
  logic        stall_ns, flush_ns, redirect_ns;
  logic [31:0] redirect_pc_ns;

  stage_id_pipe_if #(.XLEN(32), .RADDR(5)) idex_if ();
  stage_id_pipe_if #(.XLEN(32), .RADDR(5)) idex_ns_if ();

  assign idex_if.ex_ready    = ex_ready;
  assign idex_ns_if.ex_ready = ex_ready;

  always #5 clock = ~clock;

  stage_id_pipe #(.XLEN(32), .NREG(32), .RADDR(5), .DELAY_SLOT(1)) u_dut (
    .clock(clock), .reset_0(reset_0), .in_valid(in_valid), .pc_add4(pc_add4),
    .instr(instr), .wb_we(wb_we), .wb_rn(wb_rn), .wb_data(wb_data),
    .ex_we(ex_we), .ex_rn(ex_rn), .ex_is_load(ex_is_load), .ex_alu(ex_alu),
    .mem_we(mem_we), .mem_rn(mem_rn), .mem_is_load(mem_is_load),
    .mem_alu(mem_alu), .mem_mo(mem_mo), .stall_if(stall_if),
    .flush_if(flush_if), .redirect(redirect), .redirect_pc(redirect_pc),
    .idex(idex_if)
  );

  stage_id_pipe #(.XLEN(32), .NREG(32), .RADDR(5), .DELAY_SLOT(0)) u_dut_ns (
    .clock(clock), .reset_0(reset_0), .in_valid(in_valid), .pc_add4(pc_add4),
    .instr(instr), .wb_we(wb_we), .wb_rn(wb_rn), .wb_data(wb_data),
    .ex_we(ex_we), .ex_rn(ex_rn), .ex_is_load(ex_is_load), .ex_alu(ex_alu),
    .mem_we(mem_we), .mem_rn(mem_rn), .mem_is_load(mem_is_load),
    .mem_alu(mem_alu), .mem_mo(mem_mo), .stall_if(stall_ns),
    .flush_if(flush_ns), .redirect(redirect_ns), .redirect_pc(redirect_pc_ns),
    .idex(idex_ns_if)
  );

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'b0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input int rs,
                                        input int rt, input logic [15:0] imm);
    return {opc, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] opc, input logic [25:0] tgt);
    return {opc, tgt};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins,
                               input logic [31:0] pc);
    in_valid = v;
    instr    = ins;
    pc_add4  = pc;
    #1;
  endtask

  task automatic pushExp(input logic [5:0] opc, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input int rn, input logic we);
    exp_t e;
    e.op = opc; e.func = fn; e.a = a; e.b = b; e.imm = imm;
    e.rn = 5'(rn); e.we = we;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: an entry is consumed by EX on each negedge where valid && ready
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_0 === 1'b1 && idex_if.idex_valid === 1'b1 && ex_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("sb_unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("idex_op",   32'(idex_if.idex_op),   32'(e.op));
          checkOutput("idex_func", 32'(idex_if.idex_func), 32'(e.func));
          checkOutput("idex_a",    idex_if.idex_a,         e.a);
          checkOutput("idex_b",    idex_if.idex_b,         e.b);
          checkOutput("idex_imm",  idex_if.idex_imm,       e.imm);
          checkOutput("idex_rn",   32'(idex_if.idex_rn),   32'(e.rn));
          checkOutput("idex_we",   32'(idex_if.idex_we),   32'(e.we));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_0 = 1'b1; in_valid = 0; pc_add4 = 0; instr = 0;
    wb_we = 0; wb_rn = 0; wb_data = 0;
    ex_we = 0; ex_rn = 0; ex_is_load = 0; ex_alu = 0;
    mem_we = 0; mem_rn = 0; mem_is_load = 0; mem_alu = 0; mem_mo = 0;
    ex_ready = 1;
    #2 reset_0 = 1'b0;
    tick(); tick();
    checkOutput("rst_idex_valid", 32'(idex_if.idex_valid), 32'd0);
    checkOutput("rst_idex_a",     idex_if.idex_a, 32'd0);
    checkOutput("rst_idex_rn",    32'(idex_if.idex_rn), 32'd0);
    checkOutput("rst_idex_we",    32'(idex_if.idex_we), 32'd0);
    checkOutput("rst_stall_if",   32'(stall_if), 32'd0);
    checkOutput("rst_redirect",   32'(redirect), 32'd0);
    checkOutput("rst_flush_ns",   32'(flush_ns), 32'd0);
    reset_0 = 1'b1;

    // r1=5 via WB, then r2=7 written the same cycle add r3,r1,r2 reads it
    wb_we = 1; wb_rn = 1; wb_data = 32'd5;
    applyStimulus(0, 32'd0, 32'd0);
    tick();
    wb_rn = 2; wb_data = 32'd7;
    applyStimulus(1, enc_r(1, 2, 3, FN_ADD), 32'h40);
    checkOutput("add_stall_if", 32'(stall_if), 32'd0);
    pushExp(OP_RTYPE, FN_ADD, 32'd5, 32'd7, 32'h1820, 3, 1);
    tick();
    checkOutput("add_idex_valid", 32'(idex_if.idex_valid), 32'd1);

    // Forwarding priority: EX over MEM, then MEM ALU, then MEM load data
    wb_we = 0;
    ex_we = 1; ex_rn = 1; ex_alu = 32'h11; ex_is_load = 0;
    mem_we = 1; mem_rn = 1; mem_alu = 32'h22; mem_is_load = 0; mem_mo = 32'h77;
    applyStimulus(1, enc_r(1, 1, 4, FN_SUB), 32'h44);
    pushExp(OP_RTYPE, FN_SUB, 32'h11, 32'h11, 32'h2022, 4, 1);
    tick();
    ex_we = 0;
    applyStimulus(1, enc_r(1, 1, 4, FN_SUB), 32'h44);
    pushExp(OP_RTYPE, FN_SUB, 32'h22, 32'h22, 32'h2022, 4, 1);
    tick();
    mem_is_load = 1; mem_mo = 32'h33;
    applyStimulus(1, enc_r(1, 1, 4, FN_SUB), 32'h44);
    pushExp(OP_RTYPE, FN_SUB, 32'h33, 32'h33, 32'h2022, 4, 1);
    tick();

    // Load-use: lw r2 in EX, add r5,r2,r0 in ID
    mem_we = 0; mem_is_load = 0;
    ex_we = 1; ex_rn = 2; ex_is_load = 1; ex_alu = 32'hdead;
    applyStimulus(1, enc_r(2, 0, 5, FN_ADD), 32'h48);
    checkOutput("lu_stall_if", 32'(stall_if), 32'd1);
    checkOutput("lu_redirect", 32'(redirect), 32'd0);
    tick();
    checkOutput("lu_bubble_valid", 32'(idex_if.idex_valid), 32'd0);
    ex_we = 0; ex_is_load = 0;
    mem_we = 1; mem_rn = 2; mem_is_load = 1; mem_mo = 32'h99;
    applyStimulus(1, enc_r(2, 0, 5, FN_ADD), 32'h48);
    checkOutput("lu_release_stall", 32'(stall_if), 32'd0);
    pushExp(OP_RTYPE, FN_ADD, 32'h99, 32'd0, 32'h2820, 5, 1);
    tick();

    // r1 = r2 = 9
    mem_we = 0; mem_is_load = 0;
    wb_we = 1; wb_rn = 1; wb_data = 32'd9;
    applyStimulus(0, 32'd0, 32'd0);
    tick();
    wb_rn = 2;
    tick();
    wb_we = 0;

    // beq r1,r2,+4 taken
    applyStimulus(1, enc_i(OP_BEQ, 1, 2, 16'h0004), 32'h100);
    checkOutput("beq_redirect",    32'(redirect), 32'd1);
    checkOutput("beq_redirect_pc", redirect_pc, 32'h110);
    checkOutput("beq_flush_ds1",   32'(flush_if), 32'd0);
    checkOutput("beq_flush_ds0",   32'(flush_ns), 32'd1);
    checkOutput("beq_redirect_ds0", 32'(redirect_ns), 32'd1);
    pushExp(OP_BEQ, 6'h04, 32'd9, 32'd9, 32'd4, 2, 0);
    tick();

    // Same beq with r2 forwarded as 8 from EX: not taken
    ex_we = 1; ex_rn = 2; ex_alu = 32'd8;
    applyStimulus(1, enc_i(OP_BEQ, 1, 2, 16'h0004), 32'h100);
    checkOutput("beq_nt_redirect", 32'(redirect), 32'd0);
    checkOutput("beq_nt_flush_ds0", 32'(flush_ns), 32'd0);
    pushExp(OP_BEQ, 6'h04, 32'd9, 32'd8, 32'd4, 2, 0);
    tick();
    ex_we = 0;

    // jal 0x40
    applyStimulus(1, enc_j(OP_JAL, 26'h40), 32'h1004);
    checkOutput("jal_redirect",    32'(redirect), 32'd1);
    checkOutput("jal_redirect_pc", redirect_pc, 32'h100);
    checkOutput("jal_flush_ds0",   32'(flush_ns), 32'd1);
    pushExp(OP_JAL, 6'h00, 32'h1004, 32'd0, 32'h40, 31, 1);
    tick();

    // Back-pressure: load add r3, then hold it for 3 cycles with a taken
    // beq waiting in ID
    applyStimulus(1, enc_r(1, 2, 3, FN_ADD), 32'h2000);
    pushExp(OP_RTYPE, FN_ADD, 32'd9, 32'd9, 32'h1820, 3, 1);
    tick();
    ex_ready = 0;
    applyStimulus(1, enc_i(OP_BEQ, 1, 2, 16'h0004), 32'h2004);
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold_stall_if",  32'(stall_if), 32'd1);
      checkOutput("hold_redirect",  32'(redirect), 32'd0);
      checkOutput("hold_flush_ds0", 32'(flush_ns), 32'd0);
      checkOutput("hold_valid",     32'(idex_if.idex_valid), 32'd1);
      checkOutput("hold_a",         idex_if.idex_a, 32'd9);
      checkOutput("hold_rn",        32'(idex_if.idex_rn), 32'd3);
      tick();
    end

    // Reset in the middle of the hold kills the held entry at once
    #2;
    reset_0  = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("midrst_valid",    32'(idex_if.idex_valid), 32'd0);
    checkOutput("midrst_a",        idex_if.idex_a, 32'd0);
    checkOutput("midrst_stall_if", 32'(stall_if), 32'd0);
    checkOutput("midrst_redirect", 32'(redirect), 32'd0);
    checkOutput("midrst_pending",  32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
    tick();

    // First edge after reset loads normally; registers read back as zero
    reset_0  = 1'b1;
    ex_ready = 1;
    applyStimulus(1, enc_r(1, 2, 3, FN_ADD), 32'h3000);
    pushExp(OP_RTYPE, FN_ADD, 32'd0, 32'd0, 32'h1820, 3, 1);
    tick();
    applyStimulus(0, 32'd0, 32'd0);
    tick();
    tick();
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_id_pipe.md
Name: stage_id_pipe

Overview:
- Parametrised decode stage for the 5-stage MIPS pipeline: register file, EX/MEM/WB operand forwarding, branch/jump resolution in ID, load-use interlock, and the registered ID/EX boundary.
- Adds valid/stall/bubble handling, downstream back-pressure, and a selectable delay-slot or flush mode.
- Sits between the IF/ID register and stage_ex.

Parameters:
- XLEN, 32, datapath width (≥32).
- NREG, 32, architectural register count (power of 2); r0 reads as zero.
- RADDR, 5, log2(NREG).
- DELAY_SLOT, 1, 1 = branch delay slot executes; 0 = IF instruction squashed on redirect.

Ports:
- clock  in  1  rising-edge clock
- reset_0  in  1  asynchronous, active-low reset
- in_valid  in  1  IF/ID holds a valid instruction
- pc_add4  in  XLEN  PC+4 of the ID instruction
- instr  in  32  instruction word
- wb_we / wb_rn / wb_data  in  1/RADDR/XLEN  writeback port
- ex_we / ex_rn / ex_is_load / ex_alu  in  1/RADDR/1/XLEN  EX-stage destination and result
- mem_we / mem_rn / mem_is_load / mem_alu / mem_mo  in  1/RADDR/1/XLEN/XLEN  MEM-stage destination, ALU result, load data
- ex_ready  in  1  EX accepts ID/EX contents this cycle
- stall_if  out  1  hold PC and IF/ID
- flush_if  out  1  squash IF/ID (DELAY_SLOT=0 only)
- redirect / redirect_pc  out  1/XLEN  taken branch or jump and its target
- idex_valid, idex_op(6), idex_func(6), idex_a, idex_b, idex_imm(XLEN), idex_rn(RADDR), idex_we  out  registered ID/EX fields

Behaviour:
- Reset (reset_0=0, asynchronous): all idex_* = 0, all registers = 0. stall_if, flush_if and redirect are combinational, so they read 0 while idex_valid=0 and in_valid=0.
- Decode: rs=instr[25:21], rt=[20:16], rd=[15:11].
  - Destination: rd for R-type, rt for I-type, 31 for jal.
  - we = 0 for sw, beq, bne, j.
- Source-use: uses_rs for all ops except j, jal, lui. uses_rt for R-type, beq, bne, sw.
- Immediate: sign-extended for addi, lw, sw, beq, bne; zero-extended for andi, ori, xori. Extension is to XLEN.
- Register file:
  - Written on the rising edge when wb_we && wb_rn≠0.
  - Same-cycle read of wb_rn returns wb_data (write-through).
- Forwarding, per source, priority EX > MEM > regfile; a source of r0 always yields 0.
  - EX: ex_we && ex_rn==src && !ex_is_load → ex_alu.
  - MEM: mem_we && mem_rn==src → mem_mo if mem_is_load, else mem_alu.
- Load-use hazard: in_valid && ex_we && ex_is_load && ex_rn≠0 && ex_rn matches a used source.
- Branch and jump:
  - beq/bne compare the forwarded operands.
  - Branch target = pc_add4 + (imm<<2).
  - j/jal target = {pc_add4[XLEN-1:28], instr[25:0], 2'b00}.
  - jal: idex_a = pc_add4 (link value), idex_b = 0.
  - redirect requires in_valid && !hazard.
- stall_if = hazard | (idex_valid && !ex_ready).
- flush_if = redirect && !DELAY_SLOT && !stall_if.
- ID/EX update each rising edge:
  - idex_valid && !ex_ready: hold all fields.
  - Else if hazard or !in_valid: bubble (idex_valid=0, idex_we=0; other fields don't-care).
  - Else: load the decoded fields, idex_valid=1.
- Latency: one cycle from IF/ID to ID/EX. Redirect is combinational in the same cycle.
- Simultaneous events: back-pressure overrides a hazard (hold, not bubble), and redirect is suppressed while stall_if is asserted. The EX match wins over MEM and WB for the same register.
- Reset mid-operation: state is cleared immediately. The first post-reset edge loads normally.

Decomposition:
- Package stage_id_pkg: opcode/func constants (R=000000, lw=100011, sw=101011, beq=000100, bne=000101, j=000010, jal=000011, addi, andi, ori, xori, lui) and the forwarding-select enum (REG, EX, MEM_ALU, MEM_MO).
- One sub-module, id_regfile: parametrised NREG×XLEN array with 2 read ports, 1 write port, r0 = 0, write-through.

Test Plan:
- Reset then `add r3,r1,r2` with r1=5, r2=7 (written via WB) → next cycle idex_valid=1, idex_a=5, idex_b=7, idex_rn=3, idex_we=1.
- EX writes r1=0x11 and MEM writes r1=0x22, then `sub r4,r1,r1` → idex_a=idex_b=0x11. With EX removed → 0x22; with MEM a load returning 0x33 → 0x33.
- EX is `lw r2`, ID is `add r5,r2,r0` → stall_if=1 and the next idex_valid=0. The following cycle, with mem_mo=0x99 → idex_a=0x99, stall_if=0.
- `beq r1,r2,+4` with r1=r2=9, pc_add4=0x100 → redirect=1, redirect_pc=0x110. With DELAY_SLOT=0 → flush_if=1; with r2=8 → redirect=0.
- `jal 0x40`, pc_add4=0x1004 → redirect_pc=0x100, idex_rn=31, idex_a=0x1004.
- ex_ready=0 for 3 cycles with idex_valid=1 → idex_* unchanged and stall_if=1. Asserting reset_0=0 mid-hold → idex_valid=0 immediately.
